// File: rtl/bvsle_bvneg_witness_checker.sv
// Witness checker for the signed-less-or-equal / negation invertibility condition.
// A witness x for operand t is valid when (-x) <=s t, using W-bit wrap-around negation.
// For each accepted (t, x) pair the block does two things:
//   - it checks x directly;
//   - it sweeps every W-bit value to count all solutions for t.
// Results are returned on a valid/ready response port.
module bvsle_bvneg_witness_checker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_t,
  input  logic [W-1:0] req_x,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         witness_ok,
  output logic [W:0]   sol_count,
  output logic         exists,
  output logic         mismatch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] LAST_IDX = {W{1'b1}};
  localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] t_q, t_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         witness_ok_q, witness_ok_d;

  logic         rsp_valid_q, rsp_valid_d;
  logic         res_ok_q, res_ok_d;
  logic [W:0]   sol_count_q, sol_count_d;
  logic         exists_q, exists_d;
  logic         mismatch_q, mismatch_d;

  // Negation wraps at W bits, so the most negative value maps onto itself.
  function automatic logic neg_sle(input logic [W-1:0] x, input logic [W-1:0] t);
    logic [W-1:0] neg_x;
    neg_x = ~x + ONE_W;
    return $signed(neg_x) <= $signed(t);
  endfunction

  // Next-state, sweep counter and registered result computation.
  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    witness_ok_d = witness_ok_q;
    rsp_valid_d  = rsp_valid_q;
    res_ok_d     = res_ok_q;
    sol_count_d  = sol_count_q;
    exists_d     = exists_q;
    mismatch_d   = mismatch_q;
    req_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          t_d          = req_t;
          witness_ok_d = neg_sle(req_x, req_t);
          cnt_d        = '0;
          idx_d        = '0;
          state_d      = SWEEP;
        end
      end

      SWEEP: begin
        cnt_d = cnt_q + {{W{1'b0}}, neg_sle(idx_q, t_q)};
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + ONE_W;
        end
      end

      DONE: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          res_ok_d    = 1'b0;
          sol_count_d = '0;
          exists_d    = 1'b0;
          mismatch_d  = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
          res_ok_d    = witness_ok_q;
          sol_count_d = cnt_q;
          exists_d    = (cnt_q != '0);
          mismatch_d  = (cnt_q != '0) && !witness_ok_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      t_q          <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      witness_ok_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      res_ok_q     <= 1'b0;
      sol_count_q  <= '0;
      exists_q     <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      witness_ok_q <= witness_ok_d;
      rsp_valid_q  <= rsp_valid_d;
      res_ok_q     <= res_ok_d;
      sol_count_q  <= sol_count_d;
      exists_q     <= exists_d;
      mismatch_q   <= mismatch_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign witness_ok = res_ok_q;
  assign sol_count  = sol_count_q;
  assign exists     = exists_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_bvsle_bvneg_witness_checker.sv
// Scoreboard bench for bvsle_bvneg_witness_checker.
// Expected results are queued when a request is accepted.
// They are popped and compared when the response handshake happens.
module tb_bvsle_bvneg_witness_checker;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_t;
  logic [W-1:0] req_x;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         witness_ok;
  logic [W:0]   sol_count;
  logic         exists;
  logic         mismatch;

  typedef struct {
    int t;
    int x;
    int ok;
    int cnt;
  } expect_t;

  expect_t sb[$];

  int vectorCount = 0;
  int missCount = 0;
  int cycleCount = 0;
  int lastAcceptEdge = 0;
  int lastHandshakeEdge = 0;
  logic prevValid = 1'b0;

  bvsle_bvneg_witness_checker #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_t      (req_t),
    .req_x      (req_x),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .witness_ok (witness_ok),
    .sol_count  (sol_count),
    .exists     (exists),
    .mismatch   (mismatch)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used for latency and handshake timing.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v >= N / 2) ? v - N : v;
  endfunction

  function automatic int modelOk(input int t, input int x);
    return (toSigned((N - x) % N) <= toSigned(t)) ? 1 : 0;
  endfunction

  function automatic int modelCount(input int t);
    int c = 0;
    for (int x = 0; x < N; x++) c += modelOk(t, x);
    return c;
  endfunction

  // Drive one request, wait for its accept, and queue the expected result.
  task automatic applyStimulus(input int t, input int x, input int expOk, input int expCnt);
    int waitCycles = 0;
    expect_t e;
    @(negedge clk);
    req_t = t[W-1:0];
    req_x = x[W-1:0];
    req_valid = 1'b1;
    while (!req_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    e.t = t;
    e.x = x;
    e.ok = expOk;
    e.cnt = expCnt;
    sb.push_back(e);
    lastAcceptEdge = cycleCount + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_t = W'($urandom);
    req_x = W'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  // Response monitor: latency on rising rsp_valid, scoreboard compare on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && !prevValid)
        checkOutput("latency", cycleCount - lastAcceptEdge, N + 1);
      if (rsp_valid && rsp_ready) begin
        lastHandshakeEdge = cycleCount + 1;
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 1, 0);
        end else begin
          expect_t e;
          e = sb.pop_front();
          checkOutput($sformatf("witness_ok t=%0d x=%0d", e.t, e.x), witness_ok, e.ok);
          checkOutput($sformatf("sol_count t=%0d x=%0d", e.t, e.x), sol_count, e.cnt);
          checkOutput($sformatf("exists t=%0d x=%0d", e.t, e.x), exists, (e.cnt != 0) ? 1 : 0);
          checkOutput($sformatf("mismatch t=%0d x=%0d", e.t, e.x), mismatch,
                      ((e.cnt != 0) && (e.ok == 0)) ? 1 : 0);
        end
      end
    end
    prevValid = rsp_valid;
  end

  initial begin
    logic [W:0] heldCount;
    logic heldOk, heldExists, heldMismatch;
    int n;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_t = '0;
    req_x = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_sol_count", sol_count, 0);
    checkOutput("rst_witness_ok", witness_ok, 0);
    checkOutput("rst_exists", exists, 0);
    checkOutput("rst_mismatch", mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a sweep drops the request without a response.
    applyStimulus(0, 0, 1, 9);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_sol_count", sol_count, 0);
    checkOutput("midrst_req_ready", req_ready, 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 9);
    waitDrain();

    // Boundary operands.
    applyStimulus(7, 3, 1, 16);
    applyStimulus(8, 8, 1, 1);
    applyStimulus(8, 1, 0, 1);
    applyStimulus(0, 0, 1, 9);
    applyStimulus(0, 15, 0, 9);
    waitDrain();

    // Backpressure: response held, a second request waits until after the handshake.
    rsp_ready = 1'b0;
    applyStimulus(5, 2, 1, 14);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_rsp_valid", rsp_valid, 1);
    heldCount = sol_count;
    heldOk = witness_ok;
    heldExists = exists;
    heldMismatch = mismatch;
    req_t = 4'd3;
    req_x = 4'd12;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_hold_valid", rsp_valid, 1);
      checkOutput("bp_hold_count", sol_count, heldCount);
      checkOutput("bp_hold_ok", witness_ok, heldOk);
      checkOutput("bp_hold_exists", exists, heldExists);
      checkOutput("bp_hold_mismatch", mismatch, heldMismatch);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    applyStimulus(3, 12, 0, 12);
    checkOutput("bp_accept_after_handshake", lastAcceptEdge - lastHandshakeEdge, 1);
    waitDrain();

    // Every (t, x) pair against the reference model.
    for (int t = 0; t < N; t++) begin
      for (int x = 0; x < N; x++) begin
        applyStimulus(t, x, modelOk(t, x), modelCount(t));
      end
    end
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
